key_expand: RTL and testbench

KEY_EXPAND -- requirements
Module: key_expand

---
 rtl/key_expand.sv | 176 +++++++++++++++++
 tb/tb_key_expand.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_expand.sv
// AES-128 key expansion engine.
// A single start pulse sequences out the eleven round keys (rounds 0..10),
// one per clock, each computed combinationally from the previous one.
// Optional build macro KEY_EXPAND_STORE_EN adds an 11-entry round-key store
// with a combinational read port (rd_idx / rd_key).
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last emitted round key
// EXPAND | emitting round keys; leaves after the round-10 cycle
module key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] round_key,
    output logic         done
`ifdef KEY_EXPAND_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX_TBL[idx -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t         state, state_nxt;
    logic           busy_nxt, rk_valid_nxt, done_nxt;
    logic [3:0]     rk_round_nxt;
    logic [127:0]   round_key_nxt;

    logic [3:0]     rnd_inc;
    logic [31:0]    w0, w1, w2, w3, tw;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   next_key;

    assign rnd_inc = rk_round + 4'd1;

    // Next round key from the current one: RotWord, SubWord, Rcon, then the xor chain.
    always_comb begin
        w0 = round_key[127:96];
        w1 = round_key[95:64];
        w2 = round_key[63:32];
        w3 = round_key[31:0];
        tw = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(rnd_inc), 24'h000000};
        n0 = w0 ^ tw;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt     = state;
        busy_nxt      = busy;
        rk_valid_nxt  = 1'b0;
        done_nxt      = 1'b0;
        rk_round_nxt  = rk_round;
        round_key_nxt = round_key;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt     = EXPAND;
                    busy_nxt      = 1'b1;
                    rk_valid_nxt  = 1'b1;
                    rk_round_nxt  = 4'd0;
                    round_key_nxt = key_in;
                end
            end
            EXPAND: begin
                // Round 10 is on the outputs this cycle; start is ignored here
                // so the controller always spends one cycle idle.
                if (rk_round == 4'd10) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    busy_nxt      = 1'b1;
                    rk_valid_nxt  = 1'b1;
                    rk_round_nxt  = rnd_inc;
                    round_key_nxt = next_key;
                    done_nxt      = (rk_round == 4'd9);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset has priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            rk_round  <= 4'd0;
            round_key <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            rk_valid  <= rk_valid_nxt;
            done      <= done_nxt;
            rk_round  <= rk_round_nxt;
            round_key <= round_key_nxt;
        end
    end

`ifdef KEY_EXPAND_STORE_EN
    logic [127:0] store [0:10];

    // Capture each emitted round key into the slot for its round.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                store[i] <= '0;
            end
        end else if (rk_valid) begin
            store[rk_round] <= round_key;
        end
    end

    assign rd_key = (rd_idx <= 4'd10) ? store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: directed FIPS-197 and all-zero key runs,
// back-to-back start, ignored re-start, mid-run reset and rst+start collision.
module tb_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] round_key;
    logic         done;
`ifdef KEY_EXPAND_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_round  (rk_round),
        .round_key (round_key),
        .done      (done)
`ifdef KEY_EXPAND_STORE_EN
        ,
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         done;
        logic         chk_key;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_valid  = 0;
    logic [127:0] fips [0:10];
    logic [127:0] fips_key;
    logic [127:0] zk1, zk10;

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        fips_key = fips[0];
        zk1      = 128'h62636363626363636263636362636363;
        zk10     = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_fips(input int last);
        exp_t e;
        for (int i = 0; i <= last; i++) begin
            e.rnd = 4'(i); e.key = fips[i]; e.done = (i == 10); e.chk_key = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic push_zero();
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.rnd     = 4'(i);
            e.key     = (i == 1) ? zk1 : ((i == 10) ? zk10 : '0);
            e.done    = (i == 10);
            e.chk_key = (i == 0 || i == 1 || i == 10);
            sb.push_back(e);
        end
    endtask

    task automatic start_pulse(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},      128'(busy),     128'd0);
        chk({tag, "_rk_valid"},  128'(rk_valid), 128'd0);
        chk({tag, "_done"},      128'(done),     128'd0);
        chk({tag, "_rk_round"},  128'(rk_round), 128'd0);
        chk({tag, "_round_key"}, round_key,      128'd0);
    endtask

    // Monitor: every rk_valid cycle pops one expectation from the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rk_valid === 1'b1) begin
                n_valid++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rk_valid: got round %0d expected no output", rk_round);
                end else begin
                    e = sb.pop_front();
                    chk("rk_round",   128'(rk_round), 128'(e.rnd));
                    chk("done",       128'(done),     128'(e.done));
                    chk("busy_valid", 128'(busy),     128'd1);
                    if (e.chk_key) chk("round_key", round_key, e.key);
                end
            end
        end
    end

    // Stimulus driver with direct timing checks.
    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
`ifdef KEY_EXPAND_STORE_EN
        rd_idx = 4'd0;
`endif
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 run followed by a back-to-back all-zero key run.
        push_fips(10);
        start_pulse(fips_key);                      // now in cycle T+1
        chk("busy_T1", 128'(busy), 128'd1);
        repeat (10) @(negedge clk);                 // cycle T+11
        chk("done_T11", 128'(done), 128'd1);
        @(negedge clk);                             // cycle T+12
        chk("busy_T12",      128'(busy),     128'd0);
        chk("rk_valid_T12",  128'(rk_valid), 128'd0);
        chk("done_T12",      128'(done),     128'd0);
        chk("hold_round",    128'(rk_round), 128'd10);
        chk("hold_key",      round_key,      fips[10]);
        push_zero();
        start_pulse('0);                            // accepted at T+12
        chk("busy_b2b", 128'(busy), 128'd1);
        repeat (12) @(negedge clk);
        chk("pulses_runA", 128'(n_valid), 128'd22);

        // FIPS-197 run with a different key re-pulsed mid-expansion.
        push_fips(10);
        start_pulse(fips_key);                      // cycle T+1
        repeat (4) @(negedge clk);                  // cycle T+5
        start_pulse(128'hdeadbeef_00112233_44556677_8899aabb);
        repeat (8) @(negedge clk);
        chk("busy_after_B", 128'(busy), 128'd0);
        chk("pulses_runB",  128'(n_valid), 128'd33);

`ifdef KEY_EXPAND_STORE_EN
        rd_idx = 4'd1;  #1 chk("store_rd1",  rd_key, fips[1]);
        rd_idx = 4'd10; #1 chk("store_rd10", rd_key, fips[10]);
        rd_idx = 4'd15; #1 chk("store_rd15", rd_key, 128'd0);
        rd_idx = 4'd0;  #1 chk("store_rd0",  rd_key, fips[0]);
`endif

        // Reset at T+6 aborts the expansion after round 5.
        push_fips(5);
        start_pulse(fips_key);                      // cycle T+1
        repeat (5) @(negedge clk);                  // cycle T+6
        rst = 1'b1;
        @(negedge clk);                             // cycle T+7
        rst = 1'b0;
        chk_outputs_zero("midrst");
        repeat (12) @(negedge clk);
        chk("busy_after_C", 128'(busy), 128'd0);

`ifdef KEY_EXPAND_STORE_EN
        rd_idx = 4'd10; #1 chk("store_cleared", rd_key, 128'd0);
`endif

        // rst and start together: no expansion begins.
        rst    = 1'b1;
        start  = 1'b1;
        key_in = fips_key;
        @(negedge clk);
        rst    = 1'b0;
        start  = 1'b0;
        chk_outputs_zero("rst_start");
        repeat (13) @(negedge clk);
        chk("busy_after_D",  128'(busy),     128'd0);
        chk("sb_empty",      128'(sb.size()), 128'd0);
        chk("pulses_total",  128'(n_valid),  128'd39);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
